// File: rtl/rc4_ksa_engine_pkg.sv
// rc4_pkg: FSM state encoding and key-word extraction shared by the KSA engine.
package rc4_pkg;

  // Widest key vector / word the helper handles (AW <= 16, AW*KEY_LEN <= 256).
  localparam int KEY_MAXW  = 256;
  localparam int WORD_MAXW = 16;

  typedef enum logic [3:0] {
    IDLE, INIT, RD_I, WAIT_I, CALC_J, RD_J, WAIT_J, WR_J, WR_I, NEXT, DONE
  } state_t;

  // Word idx of a key packed MS-word first: key[(klen-1-idx)*aw +: aw].
  function automatic logic [WORD_MAXW-1:0] key_word(input logic [KEY_MAXW-1:0] key,
                                                    input int idx, input int aw,
                                                    input int klen);
    logic [KEY_MAXW-1:0] sh;
    sh = key >> ((klen - 1 - idx) * aw);
    return sh[WORD_MAXW-1:0] & ((WORD_MAXW'(1) << aw) - 1'b1);
  endfunction

endpackage

// File: rtl/rc4_ksa_engine_if.sv
// Start/done handshake plus S-RAM port of the KSA engine.
interface rc4_ksa_engine_if #(
  parameter int AW      = 8,
  parameter int KEY_LEN = 3
);
  logic                  start;
  logic [AW*KEY_LEN-1:0] key;
  logic                  busy;
  logic                  done;
  logic [AW-1:0]         mem_addr;
  logic [AW-1:0]         mem_wdata;
  logic                  mem_wren;
  logic [AW-1:0]         mem_rdata;

  modport slave  (input  start, key, mem_rdata,
                  output busy, done, mem_addr, mem_wdata, mem_wren);
  modport master (output start, key, mem_rdata,
                  input  busy, done, mem_addr, mem_wdata, mem_wren);
endinterface

// File: rtl/rc4_ksa_engine_rd_wait.sv
// rc4_rd_wait: read-latency down-counter. Loaded while the address is
// presented, it flags expire on the last wait cycle, when read data is valid.
module rc4_rd_wait #(
  parameter int RD_LAT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_expire
);
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  logic [CW-1:0] r_cnt;

  // Count RD_LAT wait cycles: load RD_LAT-1, then step down to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_cnt <= '0;
    else if (i_load)                 r_cnt <= CW'(RD_LAT - 1);
    else if (i_en && r_cnt != '0)    r_cnt <= r_cnt - 1'b1;
  end

  assign o_expire = i_en && (r_cnt == '0);
endmodule

// File: rtl/rc4_ksa_engine.sv
// rc4_ksa_engine: RC4 key-scheduling over an external 2**AW entry S-RAM.
// Optional macro RC4_KSA_INIT_EN adds an identity-fill INIT phase before the
// shuffle; without it the S-RAM must already hold S[a]=a when start arrives.
// Memory outputs are registered and take their value on entry to a state, so
// RD_I/RD_J present the address and WAIT_x covers the RD_LAT read latency.
module rc4_ksa_engine
  import rc4_pkg::*;
#(
  parameter int AW      = 8,
  parameter int KEY_LEN = 3,
  parameter int RD_LAT  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  rc4_ksa_engine_if.slave   bus
);
  localparam int            KW   = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
  localparam logic [AW-1:0] LAST = '1;

  state_t                r_state, w_state_n;
  logic [AW*KEY_LEN-1:0] r_key;
  logic [AW-1:0]         r_i, r_j, r_si, r_sj, r_addr, r_wdata;
  logic [KW-1:0]         r_kidx;
  logic                  r_wren, r_busy, r_done;
  logic [AW-1:0]         w_kword, w_j_new;
  logic                  w_load, w_wait, w_expire;

  assign w_kword = AW'(key_word(KEY_MAXW'(r_key), int'(r_kidx), AW, KEY_LEN));
  assign w_j_new = r_j + r_si + w_kword;
  assign w_load  = (r_state == RD_I) || (r_state == RD_J);
  assign w_wait  = (r_state == WAIT_I) || (r_state == WAIT_J);

  rc4_rd_wait #(.RD_LAT(RD_LAT)) u_rd_wait (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_load),
    .i_en     (w_wait),
    .o_expire (w_expire)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_n;
  end

  // Next-state decode.
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      IDLE:
        if (bus.start) begin
`ifdef RC4_KSA_INIT_EN
          w_state_n = INIT;
`else
          w_state_n = RD_I;
`endif
        end
      INIT:    if (r_addr == LAST) w_state_n = RD_I;
      RD_I:    w_state_n = WAIT_I;
      WAIT_I:  if (w_expire) w_state_n = CALC_J;
      CALC_J:  w_state_n = (w_j_new == r_i) ? NEXT : RD_J;
      RD_J:    w_state_n = WAIT_J;
      WAIT_J:  if (w_expire) w_state_n = WR_J;
      WR_J:    w_state_n = WR_I;
      WR_I:    w_state_n = NEXT;
      NEXT:    w_state_n = (r_i == LAST) ? DONE : RD_I;
      DONE:    w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  // Datapath and registered memory/handshake outputs. The j-write strobes in
  // WR_J; the i-write address/data settle in WR_I and strobe in NEXT, so wren
  // never stays high two cycles running and both writes land before RD_I.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key <= '0; r_i <= '0; r_j <= '0; r_si <= '0; r_sj <= '0; r_kidx <= '0;
      r_addr <= '0; r_wdata <= '0; r_wren <= 1'b0; r_busy <= 1'b0; r_done <= 1'b0;
    end else begin
      case (r_state)
        IDLE:
          if (bus.start) begin
            r_key  <= bus.key;
            r_i    <= '0;
            r_j    <= '0;
            r_kidx <= '0;
            r_busy <= 1'b1;
            r_addr <= '0;
            r_wdata <= '0;
`ifdef RC4_KSA_INIT_EN
            r_wren <= 1'b1;
`endif
          end
        INIT:
          if (r_addr == LAST) begin
            r_wren <= 1'b0;
            r_addr <= '0;
          end else begin
            r_addr  <= r_addr + 1'b1;
            r_wdata <= r_addr + 1'b1;
          end
        WAIT_I:
          if (w_expire) r_si <= bus.mem_rdata;
        CALC_J: begin
          r_j <= w_j_new;
          if (w_j_new != r_i) r_addr <= w_j_new;
        end
        WAIT_J:
          if (w_expire) begin
            r_sj    <= bus.mem_rdata;
            r_addr  <= r_j;
            r_wdata <= r_si;
            r_wren  <= 1'b1;
          end
        WR_J: begin
          r_wren  <= 1'b0;
          r_addr  <= r_i;
          r_wdata <= r_sj;
        end
        WR_I:
          r_wren <= 1'b1;
        NEXT: begin
          r_wren <= 1'b0;
          r_kidx <= (r_kidx == KW'(KEY_LEN - 1)) ? '0 : r_kidx + 1'b1;
          if (r_i == LAST) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end else begin
            r_i    <= r_i + 1'b1;
            r_addr <= r_i + 1'b1;
          end
        end
        DONE:
          r_done <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_wren  = r_wren;
endmodule

// File: tb/tb_rc4_ksa_engine.sv
// tb_rc4_ksa_engine: three engines (AW=8/KEY_LEN=3/RD_LAT=2, AW=4/KEY_LEN=5
// with RD_LAT=1 and 3), each on its own latency-accurate S-RAM model, checked
// against a plain KSA reference and a per-step cycle budget.
module tb_rc4_ksa_engine;

`ifdef RC4_KSA_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  logic clk, rst_n;
  logic [2:0]        start_r, fill_r, clr_r;
  logic [2:0][23:0]  key_r;

  wire  [2:0]             w_busy, w_done;
  wire  [2:0][31:0]       x_done_cnt, x_run_cyc, x_consec;
  wire  [2:0][255:0][7:0] x_mem;
  wire  [2:0][3:0][15:0]  x_wlog;

  int ncmp = 0, nfail = 0;
  int rs[256];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_i
    localparam int AWg  = (g == 0) ? 8 : 4;
    localparam int KLg  = (g == 0) ? 3 : 5;
    localparam int RLg  = (g == 0) ? 2 : ((g == 1) ? 1 : 3);
    localparam int DEP  = 1 << AWg;
    localparam int INITC = INIT_EN ? DEP : 0;
    localparam logic [7:0] SCR = INIT_EN ? 8'h5A : 8'h00;

    rc4_ksa_engine_if #(.AW(AWg), .KEY_LEN(KLg)) bus();
    rc4_ksa_engine #(.AW(AWg), .KEY_LEN(KLg), .RD_LAT(RLg)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus));

    logic [255:0][7:0]   mem;
    logic [RLg-1:0][7:0] rp;
    logic [3:0][15:0]    wlog;
    logic                prev_wren = 1'b0;
    int done_cnt = 0, run_cyc = 0, consec = 0, bcyc = 0, wr_n = 0;

    assign bus.start     = start_r[g];
    assign bus.key       = key_r[g][AWg*KLg-1:0];
    assign bus.mem_rdata = rp[RLg-1][AWg-1:0];
    assign w_busy[g]     = bus.busy;
    assign w_done[g]     = bus.done;
    assign x_done_cnt[g] = 32'(done_cnt);
    assign x_run_cyc[g]  = 32'(run_cyc);
    assign x_consec[g]   = 32'(consec);
    assign x_mem[g]      = mem;
    assign x_wlog[g]     = wlog;

    // Synchronous S-RAM: data for the address seen at cycle c appears at c+RD_LAT.
    always @(posedge clk) begin
      if (fill_r[g]) begin
        for (int a = 0; a < DEP; a++) mem[a] <= 8'(a) ^ SCR;
      end else if (bus.mem_wren) begin
        mem[bus.mem_addr] <= 8'(bus.mem_wdata);
      end
      rp[0] <= mem[bus.mem_addr];
      for (int k = 1; k < RLg; k++) rp[k] <= rp[k-1];
      prev_wren <= bus.mem_wren;
      bcyc <= bus.busy ? bcyc + 1 : 0;
      if (clr_r[g]) begin
        done_cnt <= 0; run_cyc <= 0; consec <= 0; wr_n <= 0;
      end else begin
        if (bus.done) begin
          done_cnt <= done_cnt + 1;
          run_cyc  <= bcyc;
        end
        if (bus.mem_wren && prev_wren && bcyc > INITC) consec <= consec + 1;
        if (bus.mem_wren && bcyc >= INITC) begin
          if (wr_n < 4) wlog[wr_n[1:0]] <= {8'(bus.mem_addr), 8'(bus.mem_wdata)};
          wr_n <= wr_n + 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Textbook KSA from identity; also returns the expected busy-cycle count.
  task automatic ref_ksa(input int aw, input int kl, input int rl,
                         input logic [23:0] key, output int cyc);
    int n, j, k, t;
    n = 1 << aw;
    j = 0;
    cyc = INIT_EN ? n : 0;
    for (int a = 0; a < n; a++) rs[a] = a;
    for (int i = 0; i < n; i++) begin
      k = int'(key >> ((kl - 1 - (i % kl)) * aw)) & (n - 1);
      j = (j + rs[i] + k) % n;
      if (j == i) cyc += 3 + rl;
      else begin
        t = rs[i]; rs[i] = rs[j]; rs[j] = t;
        cyc += 6 + 2 * rl;
      end
    end
  endtask

  task automatic go(input int g, input logic [23:0] key);
    fill_r[g] = 1'b1; clr_r[g] = 1'b1;
    @(negedge clk);
    fill_r[g] = 1'b0; clr_r[g] = 1'b0;
    key_r[g] = key; start_r[g] = 1'b1;
    @(negedge clk);
    start_r[g] = 1'b0;
  endtask

  task automatic wait_done(input int g);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if (w_done[g]) begin ok = 1'b1; break; end
    end
    chk($sformatf("done_seen[%0d]", g), int'(ok), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_i(input int n);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if (int'(g_i[0].dut.r_i) == n) begin ok = 1'b1; break; end
    end
    chk($sformatf("reach_i%0d", n), int'(ok), 1);
  endtask

  task automatic check_run(input int g, input int aw, input int kl, input int rl,
                           input logic [23:0] key, input string tag);
    int cyc, bad;
    ref_ksa(aw, kl, rl, key, cyc);
    bad = 0;
    for (int a = 0; a < (1 << aw); a++)
      if (int'(x_mem[g][a]) != rs[a]) bad++;
    chk({tag, " bytes_wrong"}, bad, 0);
    chk({tag, " cycles"}, int'(x_run_cyc[g]), cyc);
    chk({tag, " done_pulses"}, int'(x_done_cnt[g]), 1);
    chk({tag, " busy_after"}, int'(w_busy[g]), 0);
    chk({tag, " wren_back_to_back"}, int'(x_consec[g]), 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " busy"},  int'(w_busy[0]), 0);
    chk({tag, " done"},  int'(w_done[0]), 0);
    chk({tag, " wren"},  int'(g_i[0].bus.mem_wren), 0);
    chk({tag, " addr"},  int'(g_i[0].bus.mem_addr), 0);
    chk({tag, " wdata"}, int'(g_i[0].bus.mem_wdata), 0);
  endtask

  initial begin
    logic [23:0] k;
    rst_n = 1'b0; start_r = '0; fill_r = '0; clr_r = '0; key_r = '0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Key 000249: i=0 no write, i=1 j=3 -> mem[3]=1 then mem[1]=3; full run.
    go(0, 24'h000249);
    wait_done(0);
    chk("k249 write0", int'(x_wlog[0][0]), 'h0301);
    chk("k249 write1", int'(x_wlog[0][1]), 'h0103);
    check_run(0, 8, 3, 2, 24'h000249, "k249");

    // Zero key: first swap at i=2, j=3.
    go(0, 24'h000000);
    wait_done(0);
    chk("k0 write0", int'(x_wlog[0][0]), 'h0302);
    chk("k0 write1", int'(x_wlog[0][1]), 'h0203);
    check_run(0, 8, 3, 2, 24'h000000, "k0");

    // A second start at i=100 must be ignored.
    go(0, 24'h000249);
    wait_i(100);
    start_r[0] = 1'b1;
    @(negedge clk);
    start_r[0] = 1'b0;
    wait_done(0);
    check_run(0, 8, 3, 2, 24'h000249, "restart_ignored");

    // Reset mid-run at i=50, then a fresh run.
    k = 24'($urandom);
    go(0, k);
    wait_i(50);
    rst_n = 1'b0;
    #1 chk_reset("midrun_reset");
    @(negedge clk);
    chk_reset("midrun_reset_hold");
    rst_n = 1'b1;
    @(negedge clk);
    k = 24'($urandom);
    go(0, k);
    wait_done(0);
    check_run(0, 8, 3, 2, k, "after_reset");

    // Random keys on the small engines with RD_LAT 1 and 3.
    for (int g = 1; g < 3; g++) begin
      for (int r = 0; r < 3; r++) begin
        k = 24'($urandom_range(0, 24'hFFFFF));
        go(g, k);
        wait_done(g);
        check_run(g, 4, 5, (g == 1) ? 1 : 3, k, $sformatf("aw4_rl%0d_r%0d", (g == 1) ? 1 : 3, r));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
